// File: rtl/flick_arbiter.sv
// -----------------------------------------------------------------------------
// flick_arbiter
//   Shares one flasher between N_REQ requesters. A round-robin winner is
//   granted, the flasher is kicked with a one-cycle FLICK, and the grant is
//   held until the LED bus shows the flasher finished (two consecutive zero
//   samples after it first went nonzero) or until a RUN timeout expires.
//
// Handshake: REQ[i] is a level request. Once a grant is issued the sequence
//   always runs to DONE or ERR, whatever REQ does meanwhile. A request not
//   served yet stays pending and is looked at again on the next IDLE cycle.
//
// Ports
//   CLK        in   clock, all state on posedge
//   RST        in   asynchronous active-low reset
//   REQ        in   [N_REQ] level requests
//   LED_IN     in   [16] LED bus from the flasher
//   FLICK      out  one-cycle start pulse (ISSUE state)
//   GNT        out  [N_REQ] one-hot grant
//   BUSY       out  high whenever the FSM is not IDLE
//   DONE       out  one-cycle pulse, sequence completed (GNT still set)
//   ERR        out  one-cycle pulse, sequence timed out (GNT still set)
//   DBG_STATE  out  [2] current FSM state (0 IDLE,1 ISSUE,2 RUN,3 CLEAR)
// -----------------------------------------------------------------------------
module flick_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] REQ,
  input  logic [15:0]      LED_IN,
  output logic             FLICK,
  output logic [N_REQ-1:0] GNT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [1:0]       DBG_STATE
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_started, w_started_nxt;
  logic             r_zero, w_zero_nxt;   // one zero sample already seen

  logic             w_any;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_ptr_adv;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_led_zero;
  logic             w_complete;
  logic             w_timeout;

  // Round-robin search starting at r_ptr, wrapping modulo N_REQ.
  always_comb begin : p_rr
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % N_REQ);
      if (!w_any && REQ[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_ptr_adv  = (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_led_zero = (LED_IN == 16'h0000);
  // Completion needs the flasher to have started and this to be the second
  // zero in a row; a lone zero between nonzero samples is just a minimum.
  assign w_complete = r_started && r_zero && w_led_zero;
  // w_cnt_inc is the 1-based RUN cycle number of the current cycle.
  assign w_timeout  = (w_cnt_inc >= TO_VAL);

  always_comb begin : p_next
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_started_nxt = r_started;
    w_zero_nxt    = r_zero;
    FLICK         = 1'b0;
    DONE          = 1'b0;
    ERR           = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = '0;
        if (w_any) begin
          w_gnt_nxt[w_win] = 1'b1;
          w_ptr_nxt        = w_ptr_adv;
          w_state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        FLICK         = 1'b1;
        w_cnt_nxt     = '0;
        w_started_nxt = 1'b0;
        w_zero_nxt    = 1'b0;
        w_state_nxt   = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = w_cnt_inc;
        // Completion takes priority over a timeout landing on the same cycle.
        if (w_complete) begin
          DONE        = 1'b1;
          w_gnt_nxt   = '0;
          w_state_nxt = S_CLEAR;
        end else if (w_timeout) begin
          ERR         = 1'b1;
          w_gnt_nxt   = '0;
          w_state_nxt = S_CLEAR;
        end else if (w_led_zero) begin
          if (r_started) w_zero_nxt = 1'b1;
        end else begin
          w_started_nxt = 1'b1;
          w_zero_nxt    = 1'b0;
        end
      end
      S_CLEAR: begin
        w_gnt_nxt     = '0;
        w_cnt_nxt     = '0;
        w_started_nxt = 1'b0;
        w_zero_nxt    = 1'b0;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_started <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_started <= w_started_nxt;
      r_zero    <= w_zero_nxt;
    end
  end

  assign GNT       = r_gnt;
  assign BUSY      = (r_state != S_IDLE);
  assign DBG_STATE = r_state;

endmodule

// File: doc/flick_arbiter.md
FLICK_ARBITER -- requirements
Module: flick_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters sharing one bound flasher.
REQ-002 Parameter TIMEOUT, default 255, max cycles allowed in RUN before abort.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 REQ  input  N_REQ  level request per requester; held until that requester's DONE.
REQ-006 LED_IN  input  16  LED bus sampled from the flasher.
REQ-007 FLICK  output  1  start pulse to the flasher.
REQ-008 GNT  output  N_REQ  one-hot grant; at most one bit set.
REQ-009 BUSY  output  1  high in every state except IDLE.
REQ-010 DONE  output  1  one-cycle pulse: granted sequence completed.
REQ-011 ERR  output  1  one-cycle pulse: granted sequence timed out.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, RUN, and CLEAR.
REQ-013 IDLE: if any REQ bit is set, pick the winner round-robin starting at index PTR, set GNT to the winner, go to ISSUE; otherwise stay, with GNT=0.
REQ-014 Round-robin: search order PTR, PTR+1, ..., wrapping modulo N_REQ; on grant, PTR becomes winner+1 mod N_REQ.
REQ-015 ISSUE: FLICK SHALL be 1 for exactly this one cycle; the next state is RUN; FLICK SHALL be 0 in all other states.
REQ-016 RUN: a started flag SHALL set on the first cycle LED_IN != 0.
REQ-017 RUN: after started is set, two consecutive samples of LED_IN == 16'h0000 complete the sequence.
REQ-018 A single zero sample followed by a nonzero sample is a mid-sequence minimum, not completion; the zero count resets.
REQ-019 On completion, DONE SHALL pulse one cycle with GNT still asserted, and the next state is CLEAR.
REQ-020 RUN cycle counter: 8+ bits, cleared on entry to RUN, saturating.
REQ-021 If the RUN counter reaches TIMEOUT without completion, ERR SHALL pulse one cycle with GNT asserted, and the next state is CLEAR.
REQ-022 CLEAR: GNT drops to 0, the started flag and counters clear, the next state is IDLE; a new grant is possible no earlier than the following cycle.
REQ-023 REQ deasserted by the granted requester during ISSUE or RUN SHALL be ignored; the sequence runs to DONE or ERR.
REQ-024 Requests arriving while BUSY are not lost; they are evaluated on the next IDLE.
REQ-025 Simultaneous DONE and timeout conditions in the same cycle: DONE wins, and ERR stays 0.
REQ-026 DONE and ERR SHALL never be asserted together; GNT SHALL never be multi-hot.

Reset
REQ-027 RST low SHALL asynchronously force state=IDLE, PTR=0, GNT=0, FLICK=0, BUSY=0, DONE=0, ERR=0, and clear the counters and started flag.
REQ-028 Reset asserted mid-RUN SHALL abort without a DONE or ERR pulse; after release, behaviour starts from IDLE with PTR=0.

Verification
REQ-029 Reset release, then REQ=3'b001: GNT=001, FLICK pulses once, BUSY=1; the flasher runs its full sequence; DONE pulses once LED_IN has read 0 twice; GNT=000 one cycle later.
REQ-030 REQ=3'b111 held continuously: grants ordered 001, 010, 100, 001, each with exactly one FLICK and one DONE.
REQ-031 LED_IN sequence ...,3,1,0,1,3,...: no DONE at the single 0; DONE only at the final 0,0.
REQ-032 LED_IN stuck at 16'h0001 after FLICK: ERR pulses at RUN cycle 255; DONE=0; the FSM returns to IDLE via CLEAR.
REQ-033 RST pulsed low mid-RUN: all outputs 0 immediately; DONE=0 and ERR=0; the next grant goes to index 0.
REQ-034 REQ[1] drops during RUN: GNT=010 is held until DONE; no second FLICK is issued.
